// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial WIDTH-bit subtractor, diff = a - b, LSB first.
// One bit pair is fed through a full-subtractor cell per cycle. A start/done
// handshake gives one result every WIDTH+1 cycles. Back-to-back operation is
// possible because start is accepted in the DONE cycle.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds a signed overflow output.

// 1-bit full-subtractor cell: d = m - n - bin, bout = borrow out
module full_sub_cell (
  input  logic m,
  input  logic n,
  input  logic bin,
  output logic d,
  output logic bout
);
  // purely combinational difference/borrow equations
  always_comb begin
    d    = m ^ n ^ bin;
    bout = (~m & n) | (~m & bin) | (n & bin);
  end
endmodule

module serial_subtract_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  // counter is wide enough to hold WIDTH-1; it clears on every load so it never wraps
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             cell_d;
  logic             cell_bout;

  full_sub_cell u_cell (
    .m    (a_sr[0]),
    .n    (b_sr[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // result register moves right with the fresh difference bit entering at the MSB;
  // written as shift-then-set so WIDTH=1 needs no special slice
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = cell_d;
  end

  // control FSM with registered outputs; datapath shifts while in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      borrow     <= 1'b0;
      count      <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts start exactly like IDLE so operations can run back to back
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        // start is ignored here; a/b were captured at the load edge
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res    <= res_next;
          borrow <= cell_bout;
          count  <= count + 1'b1;
          if (count == LAST) begin
            diff       <= res_next;
            borrow_out <= cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // signed overflow: borrow into the MSB cell differs from borrow out of it
            overflow   <= borrow ^ cell_bout;
`endif
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed self-checking bench for serial_subtract_ctrl (WIDTH=8 and WIDTH=1).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// "Cycle k" is the cycle after the k-th edge that follows the start cycle (cycle 0).
module tb_serial_subtract_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, borrow_out;
  logic [7:0] diff;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1, borrow_out1;
  logic [0:0] diff1;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       overflow, overflow1;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtract_ctrl #(.WIDTH(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  serial_subtract_ctrl #(.WIDTH(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (borrow_out1)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow   (overflow1)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    checks++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset_w8 busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow_out);
    end
    checks++;
    if ({busy1, done1, diff1, borrow_out1} !== 4'd0) begin
      errors++;
      $display("FAIL reset_w1 busy=%b done=%b diff=%h borrow=%b, want all 0", busy1, done1, diff1, borrow_out1);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf overflow=%b want 0", overflow);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // 0x35 - 0x12: busy through cycles 1..8, done only in cycle 9
  task automatic test_basic();
    int bad = 0;
    start = 1'b1; a = 8'h35; b = 8'h12;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_busy %0d bad cycles in 1..8, want busy=1 done=0", bad);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'h23 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%b busy=%b diff=%h borrow=%b, want 1 0 23 0", done, busy, diff, borrow_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || diff !== 8'h23) begin
      errors++;
      $display("FAIL basic_after done=%b diff=%h, want 0 23", done, diff);
    end
  endtask

  // 0x12-0x35 then 0x00-0x01 started in the DONE cycle
  task automatic test_back_to_back();
    int bad = 0;
    start = 1'b1; a = 8'h12; b = 8'h35;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    checks++;
    if (done !== 1'b1 || diff !== 8'hDD || borrow_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first done=%b diff=%h borrow=%b, want 1 dd 1", done, diff, borrow_out);
    end
    start = 1'b1; a = 8'h00; b = 8'h01;
    tick();
    start = 1'b0; a = 8'h77; b = 8'h11;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept busy=%b done=%b, want 1 0", busy, done);
    end
    for (int c = 1; c <= 8; c++) begin
      if (done !== 1'b0 || diff !== 8'hDD || borrow_out !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_hold %0d bad cycles, want done=0 diff=dd held", bad);
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'hFF || borrow_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second done=%b diff=%h borrow=%b, want 1 ff 1", done, diff, borrow_out);
    end
    tick();
  endtask

  // start pulse and operand change in cycle 4 must not disturb 0xFF-0x0F
  task automatic test_ignore_busy();
    start = 1'b1; a = 8'hFF; b = 8'h0F;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) tick();
    start = 1'b1; a = 8'h00; b = 8'h00;
    tick();
    start = 1'b0;
    for (int c = 5; c <= 8; c++) tick();
    checks++;
    if (done !== 1'b1 || diff !== 8'hF0 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy done=%b diff=%h borrow=%b, want 1 f0 0", done, diff, borrow_out);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  // async reset in cycle 5 of 0xAA-0x55 aborts; then 0x55-0x55
  task automatic test_reset_abort();
    int seen = 0;
    start = 1'b1; a = 8'hAA; b = 8'h55;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_now busy=%b done=%b diff=%h borrow=%b, want 0 0 00 0", busy, done, diff, borrow_out);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet %0d cycles with busy/done set, want 0", seen);
    end
    start = 1'b1; a = 8'h55; b = 8'h55;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    checks++;
    if (done !== 1'b1 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_next done=%b diff=%h borrow=%b, want 1 00 0", done, diff, borrow_out);
    end
    tick();
  endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
  task automatic test_overflow();
    start = 1'b1; a = 8'h80; b = 8'h01;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    checks++;
    if (done !== 1'b1 || diff !== 8'h7F || borrow_out !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set done=%b diff=%h borrow=%b ovf=%b, want 1 7f 0 1", done, diff, borrow_out, overflow);
    end
    start = 1'b1; a = 8'h05; b = 8'h03;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    checks++;
    if (done !== 1'b1 || diff !== 8'h02 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr done=%b diff=%h ovf=%b, want 1 02 0", done, diff, overflow);
    end
    tick();
  endtask
`endif

  // WIDTH=1: 0 - 1 gives diff=1, borrow=1, done in cycle 2
  task automatic test_width1();
    start1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_busy busy=%b done=%b, want 1 0", busy1, done1);
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || diff1 !== 1'b1 || borrow_out1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_done done=%b busy=%b diff=%b borrow=%b, want 1 0 1 1", done1, busy1, diff1, borrow_out1);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (overflow1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_ovf overflow=%b want 1", overflow1);
    end
`endif
    tick();
    checks++;
    if (done1 !== 1'b0 || diff1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_after done=%b diff=%b, want 0 1", done1, diff1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
`ifdef SERIAL_SUB_OVERFLOW_EN
    test_overflow();
`endif
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
